// File: rtl/conv_pkg.sv
// Shared constants and the saturation helper for the 8x8 image, 3x3 kernel,
// three-channel valid convolution.
package conv_pkg;

    localparam int IMG_W   = 8;
    localparam int K       = 3;
    localparam int N_CH    = 3;
    localparam int OUT_W   = IMG_W - K + 1;
    localparam int DW      = 8;
    localparam int ACC_W   = 20;
    localparam int SAT_MAX = 255;

    localparam int PROD_W   = 2 * DW;
    localparam int N_TAPS   = K * K;
    localparam int N_OUT    = N_CH * OUT_W * OUT_W;
    localparam int IMG_BITS = IMG_W * IMG_W * DW;
    localparam int WGT_BITS = N_CH * N_TAPS * DW;
    localparam int OUT_BITS = N_OUT * DW;

    // Clamp a full-width accumulator to the 8-bit result range.
    function automatic logic [DW-1:0] saturate(input logic [ACC_W-1:0] acc);
        return (acc > ACC_W'(SAT_MAX)) ? DW'(SAT_MAX) : acc[DW-1:0];
    endfunction

endpackage

// File: rtl/conv_window_mac.sv
// One 3x3 window dot product with saturation to 8 bits; purely combinational.
module conv_window_mac
    import conv_pkg::*;
(
    input  logic [N_TAPS-1:0][DW-1:0] i_pix,
    input  logic [N_TAPS-1:0][DW-1:0] i_wgt,
    output logic [DW-1:0]             o_res
);

    logic [PROD_W-1:0] w_prod [N_TAPS];
    logic [ACC_W-1:0]  w_acc;

    always_comb begin
        w_acc = '0;
        for (int t = 0; t < N_TAPS; t++) begin
            w_prod[t] = PROD_W'(i_pix[t]) * PROD_W'(i_wgt[t]);
            w_acc     = w_acc + ACC_W'(w_prod[t]);
        end
    end

    assign o_res = saturate(w_acc);

endmodule

// File: rtl/conv_module.sv
// Three-channel valid 3x3 cross-correlation over an 8x8 image: all 108 windows
// evaluated in parallel and captured into a single output register.
module conv_module
    import conv_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [IMG_BITS-1:0] data_lin,
    input  logic [WGT_BITS-1:0] weight_lin,
    output logic [OUT_BITS-1:0] conv_lin
);

    logic [N_OUT-1:0][DW-1:0] w_res;
    logic [OUT_BITS-1:0]      r_conv;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        for (genvar r = 0; r < OUT_W; r++) begin : g_row
            for (genvar c = 0; c < OUT_W; c++) begin : g_col
                logic [N_TAPS-1:0][DW-1:0] w_pix;
                logic [N_TAPS-1:0][DW-1:0] w_wgt;

                // No kernel flip: tap (kr,kc) pairs with pixel (r+kr, c+kc).
                for (genvar kr = 0; kr < K; kr++) begin : g_kr
                    for (genvar kc = 0; kc < K; kc++) begin : g_kc
                        assign w_pix[kr*K + kc] = data_lin[((r + kr) * IMG_W + (c + kc)) * DW +: DW];
                        assign w_wgt[kr*K + kc] = weight_lin[(ch * N_TAPS + kr * K + kc) * DW +: DW];
                    end
                end

                conv_window_mac u_mac (
                    .i_pix (w_pix),
                    .i_wgt (w_wgt),
                    .o_res (w_res[ch * OUT_W * OUT_W + r * OUT_W + c])
                );
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conv <= '0;
        end else begin
            r_conv <= w_res;
        end
    end

    assign conv_lin = r_conv;

endmodule

// File: tb/tb_conv_module.sv
// Self-checking bench for conv_module: directed orientation/saturation/latency
// scenarios plus a back-to-back random stream scored against a reference model.
module tb_conv_module;

    logic         clk;
    logic         rst;
    logic [511:0] data;
    logic [215:0] wgt;
    logic [863:0] conv;

    logic [863:0] expQ[$];
    int           total = 0;
    int           bad   = 0;

    conv_module dut (
        .clk        (clk),
        .rst        (rst),
        .data_lin   (data),
        .weight_lin (wgt),
        .conv_lin   (conv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [863:0] golden(input logic [511:0] d, input logic [215:0] w);
        logic [863:0] res;
        int           acc;
        res = '0;
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 6; c++) begin
                    acc = 0;
                    for (int kr = 0; kr < 3; kr++)
                        for (int kc = 0; kc < 3; kc++)
                            acc += int'(d[((r + kr) * 8 + c + kc) * 8 +: 8]) *
                                   int'(w[(ch * 9 + kr * 3 + kc) * 8 +: 8]);
                    res[(ch * 36 + r * 6 + c) * 8 +: 8] = (acc > 255) ? 8'd255 : acc[7:0];
                end
        return res;
    endfunction

    function automatic int firstDiff(input logic [863:0] a, input logic [863:0] b);
        for (int i = 0; i < 108; i++)
            if (a[i*8 +: 8] !== b[i*8 +: 8]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        rst  = 1'b1;
        data = '0;
        wgt  = '0;
        #2;
        total++;
        if (conv !== '0) begin
            bad++;
            $display("[TB] FAIL reset_initial: got byte0=%0h want 0", conv[7:0]);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (conv !== '0) begin
            bad++;
            $display("[TB] FAIL reset_held: byte%0d got %0h want 0", firstDiff(conv, '0),
                     conv[firstDiff(conv, '0) * 8 +: 8]);
        end
        data = {64{8'd1}};
        wgt  = {27{8'd1}};
        expQ.push_back(golden(data, wgt));
        rst = 1'b0;
    endtask

    // First edge after release must already load the presented all-ones input.
    task automatic test_ones();
        logic [863:0] exp;
        logic [863:0] nine;
        @(posedge clk);
        #1;
        nine = {108{8'd9}};
        exp  = expQ.pop_front();
        total++;
        if (conv !== exp || conv !== nine) begin
            bad++;
            $display("[TB] FAIL ones: byte%0d got %0d want 9", firstDiff(conv, nine),
                     conv[firstDiff(conv, nine) * 8 +: 8]);
        end
    endtask

    task automatic test_orientation();
        logic [863:0] exp;
        logic [863:0] got;
        data = '0;
        wgt  = '0;
        data[7:0] = 8'd10;
        wgt[7:0]  = 8'd3;
        exp = '0;
        exp[7:0] = 8'd30;
        expQ.push_back(exp);
        @(posedge clk);
        #1;
        got = expQ.pop_front();
        total++;
        if (conv !== got) begin
            bad++;
            $display("[TB] FAIL orient_first: byte%0d got %0d want %0d", firstDiff(conv, got),
                     conv[firstDiff(conv, got) * 8 +: 8], got[firstDiff(conv, got) * 8 +: 8]);
        end

        data = '0;
        wgt  = '0;
        data[63*8 +: 8] = 8'd5;
        wgt[26*8 +: 8]  = 8'd4;
        exp = '0;
        exp[107*8 +: 8] = 8'd20;
        expQ.push_back(exp);
        @(posedge clk);
        #1;
        got = expQ.pop_front();
        total++;
        if (conv !== got) begin
            bad++;
            $display("[TB] FAIL orient_last: byte%0d got %0d want %0d", firstDiff(conv, got),
                     conv[firstDiff(conv, got) * 8 +: 8], got[firstDiff(conv, got) * 8 +: 8]);
        end
    endtask

    task automatic test_saturation();
        logic [863:0] exp;
        data = {64{8'hFF}};
        wgt  = {27{8'hFF}};
        expQ.push_back({108{8'hFF}});
        @(posedge clk);
        #1;
        exp = expQ.pop_front();
        total++;
        if (conv !== exp) begin
            bad++;
            $display("[TB] FAIL sat_full: byte%0d got %0d want 255", firstDiff(conv, exp),
                     conv[firstDiff(conv, exp) * 8 +: 8]);
        end

        data = '0;
        wgt  = '0;
        for (int i = 0; i < 4; i++) data[i*8 +: 8] = 8'd28;
        for (int i = 0; i < 3; i++) wgt[(9 + i) * 8 +: 8] = 8'd1;
        expQ.push_back(golden(data, wgt));
        @(posedge clk);
        #1;
        exp = expQ.pop_front();
        total++;
        if (conv[36*8 +: 8] !== 8'd84) begin
            bad++;
            $display("[TB] FAIL sat_ch1_00: got %0d want 84", conv[36*8 +: 8]);
        end
        total++;
        if (conv[37*8 +: 8] !== 8'd84) begin
            bad++;
            $display("[TB] FAIL sat_ch1_01: got %0d want 84", conv[37*8 +: 8]);
        end
        total++;
        if (conv !== exp) begin
            bad++;
            $display("[TB] FAIL sat_partial: byte%0d got %0d want %0d", firstDiff(conv, exp),
                     conv[firstDiff(conv, exp) * 8 +: 8], exp[firstDiff(conv, exp) * 8 +: 8]);
        end
    endtask

    // Mid-cycle input changes must not leak through; mid-cycle reset must.
    task automatic test_latency();
        logic [863:0] expA;
        logic [863:0] expB;
        logic [863:0] exp;
        for (int i = 0; i < 64; i++) data[i*8 +: 8] = 8'($urandom_range(0, 30));
        for (int i = 0; i < 27; i++) wgt[i*8 +: 8] = 8'($urandom_range(0, 3));
        expA = golden(data, wgt);
        expQ.push_back(expA);
        @(posedge clk);
        #1;
        exp = expQ.pop_front();
        total++;
        if (conv !== exp) begin
            bad++;
            $display("[TB] FAIL lat_load: byte%0d got %0d want %0d", firstDiff(conv, exp),
                     conv[firstDiff(conv, exp) * 8 +: 8], exp[firstDiff(conv, exp) * 8 +: 8]);
        end

        @(negedge clk);
        for (int i = 0; i < 64; i++) data[i*8 +: 8] = 8'($urandom_range(0, 30));
        data[7:0] = 8'd200;
        expB = golden(data, wgt);
        #1;
        total++;
        if (conv !== expA) begin
            bad++;
            $display("[TB] FAIL lat_hold: byte%0d got %0d want %0d", firstDiff(conv, expA),
                     conv[firstDiff(conv, expA) * 8 +: 8], expA[firstDiff(conv, expA) * 8 +: 8]);
        end
        @(posedge clk);
        #1;
        total++;
        if (conv !== expB) begin
            bad++;
            $display("[TB] FAIL lat_next: byte%0d got %0d want %0d", firstDiff(conv, expB),
                     conv[firstDiff(conv, expB) * 8 +: 8], expB[firstDiff(conv, expB) * 8 +: 8]);
        end

        #2;
        rst = 1'b1;
        #1;
        total++;
        if (conv !== '0) begin
            bad++;
            $display("[TB] FAIL rst_async: byte%0d got %0d want 0", firstDiff(conv, '0),
                     conv[firstDiff(conv, '0) * 8 +: 8]);
        end
        @(posedge clk);
        #1;
        total++;
        if (conv !== '0) begin
            bad++;
            $display("[TB] FAIL rst_hold: byte%0d got %0d want 0", firstDiff(conv, '0),
                     conv[firstDiff(conv, '0) * 8 +: 8]);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) data[i*8 +: 8] = 8'($urandom_range(0, 30));
        expQ.push_back(golden(data, wgt));
        @(posedge clk);
        #1;
        exp = expQ.pop_front();
        total++;
        if (conv !== exp) begin
            bad++;
            $display("[TB] FAIL rst_release: byte%0d got %0d want %0d", firstDiff(conv, exp),
                     conv[firstDiff(conv, exp) * 8 +: 8], exp[firstDiff(conv, exp) * 8 +: 8]);
        end
    endtask

    task automatic test_back_to_back();
        logic [863:0] exp;
        for (int i = 0; i < 27; i++) wgt[i*8 +: 8] = 8'($urandom_range(0, 2));
        for (int n = 0; n <= 100; n++) begin
            if (n > 0) begin
                total++;
                if (expQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL b2b_queue: image %0d got empty want entry", n - 1);
                end else begin
                    exp = expQ.pop_front();
                    if (conv !== exp) begin
                        bad++;
                        $display("[TB] FAIL b2b_img%0d: byte%0d got %0d want %0d", n - 1,
                                 firstDiff(conv, exp), conv[firstDiff(conv, exp) * 8 +: 8],
                                 exp[firstDiff(conv, exp) * 8 +: 8]);
                    end
                end
            end
            if (n < 100) begin
                for (int i = 0; i < 64; i++) data[i*8 +: 8] = 8'($urandom_range(0, 40));
                expQ.push_back(golden(data, wgt));
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_orientation();
        test_saturation();
        test_latency();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
